// File: rtl/aibcr3_dcc_dlyctrl.sv
// ---------------------------------------------------------------------------
// aibcr3_dcc_dlyctrl
//
// Delay-line controller for the DCC delay-cell chain. It turns up/down
// decisions from the duty-cycle detector into a registered thermometer bus
// `bk`. The controller:
//   - integrates the detector decisions in a signed filter;
//   - moves the code one cell per filter overflow;
//   - waits SETTLE_CYC cycles after each code change before it trusts the
//     detector again;
//   - declares lock after LOCK_REV consecutive direction reversals;
//   - flags saturation when a step is blocked at 0 or NCELL.
//
// Ports
//   clk          controller clock, rising edge
//   rst_n        asynchronous active-low reset
//   dcc_en       loop enable (synchronous)
//   up / dn      detector requests: more / less delay (sampled in TRACK/LOCKED)
//   manual_en    override: code follows manual_code (clamped to NCELL)
//   manual_code  override code
//   bk           thermometer select, bk[i] = (i < code), registered
//   code         current binary code, registered
//   lock         loop locked
//   sat          last step request was blocked at 0 or NCELL
// ---------------------------------------------------------------------------
module aibcr3_dcc_dlyctrl #(
  parameter int NCELL      = 16,
  parameter int CW         = 5,
  parameter int FILT_MAX   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_REV   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dcc_en,
  input  logic             up,
  input  logic             dn,
  input  logic             manual_en,
  input  logic [CW-1:0]    manual_code,
  output logic [NCELL-1:0] bk,
  output logic [CW-1:0]    code,
  output logic             lock,
  output logic             sat
);

  localparam int FW = $clog2(FILT_MAX) + 2;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int RW = $clog2(LOCK_REV + 1);

  localparam logic [CW-1:0]        CODE_MAX    = CW'(NCELL);
  localparam logic [CW-1:0]        CODE_MID    = CW'(NCELL / 2);
  localparam logic signed [FW-1:0] FILT_P      = FW'(FILT_MAX);
  localparam logic signed [FW-1:0] FILT_N      = -FILT_P;
  localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0]        REV_MAX     = RW'(LOCK_REV);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  // Registered state
  state_e                state_q;
  logic [CW-1:0]         code_q;
  logic [NCELL-1:0]      bk_q;
  logic                  lock_q;
  logic                  sat_q;
  logic signed [FW-1:0]  filt_q;
  logic [SW-1:0]         settle_q;
  logic [RW-1:0]         rev_q;
  dir_e                  dir_q;
  // Set while the manual override holds the code, so that a release with
  // dcc_en=1 restarts from the manual code instead of the mid-scale code.
  logic                  man_q;

  // Next-state values
  state_e                state_d;
  logic [CW-1:0]         code_d;
  logic                  lock_d;
  logic                  sat_d;
  logic signed [FW-1:0]  filt_d;
  logic [SW-1:0]         settle_d;
  logic [RW-1:0]         rev_d;
  dir_e                  dir_d;
  logic                  man_d;

  // Step evaluation helpers
  logic signed [FW-1:0]  delta;
  logic signed [FW-1:0]  filt_sum;
  dir_e                  step_dir;
  logic                  blocked;
  logic [RW-1:0]         rev_inc;

  // bk is decoded from the next code and registered, so it changes on the
  // same edge as code and never glitches.
  function automatic logic [NCELL-1:0] thermo(input logic [CW-1:0] c);
    logic [NCELL-1:0] t;
    t = '0;
    for (int i = 0; i < NCELL; i++) begin
      t[i] = (i < int'(c));
    end
    return t;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    code_d   = code_q;
    lock_d   = lock_q;
    sat_d    = sat_q;
    filt_d   = filt_q;
    settle_d = settle_q;
    rev_d    = rev_q;
    dir_d    = dir_q;
    man_d    = man_q;
    delta    = '0;
    filt_sum = filt_q;
    step_dir = DIR_NONE;
    blocked  = 1'b0;
    rev_inc  = (rev_q == REV_MAX) ? rev_q : rev_q + 1'b1;

    if (manual_en) begin
      // Override wins over everything but reset; loop is parked in IDLE.
      state_d  = IDLE;
      code_d   = (manual_code > CODE_MAX) ? CODE_MAX : manual_code;
      lock_d   = 1'b0;
      sat_d    = 1'b0;
      filt_d   = '0;
      settle_d = '0;
      rev_d    = '0;
      dir_d    = DIR_NONE;
      man_d    = 1'b1;
    end else if (!dcc_en) begin
      state_d  = IDLE;
      code_d   = '0;
      lock_d   = 1'b0;
      sat_d    = 1'b0;
      filt_d   = '0;
      settle_d = '0;
      rev_d    = '0;
      dir_d    = DIR_NONE;
      man_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          code_d   = man_q ? code_q : CODE_MID;
          man_d    = 1'b0;
          filt_d   = '0;
          settle_d = '0;
          state_d  = SETTLE;
        end

        SETTLE: begin
          filt_d = '0;
          if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            state_d  = lock_q ? LOCKED : TRACK;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end

        TRACK, LOCKED: begin
          if (up && !dn) begin
            delta = FW'(1);
          end else if (dn && !up) begin
            delta = '1;
          end
          filt_sum = filt_q + delta;
          filt_d   = filt_sum;

          if (filt_sum == FILT_P) begin
            step_dir = DIR_UP;
          end else if (filt_sum == FILT_N) begin
            step_dir = DIR_DN;
          end

          if (step_dir != DIR_NONE) begin
            filt_d  = '0;
            blocked = (step_dir == DIR_UP) ? (code_q == CODE_MAX)
                                           : (code_q == '0);
            dir_d   = step_dir;
            if (blocked) begin
              // A blocked step breaks any reversal run and any lock.
              sat_d   = 1'b1;
              rev_d   = '0;
              lock_d  = 1'b0;
              state_d = TRACK;
            end else begin
              sat_d    = 1'b0;
              code_d   = (step_dir == DIR_UP) ? code_q + 1'b1 : code_q - 1'b1;
              settle_d = '0;
              state_d  = SETTLE;
              if (dir_q == step_dir) begin
                // Two consecutive same-direction steps: the loop is moving,
                // not dithering, so lock is dropped.
                rev_d  = '0;
                lock_d = 1'b0;
              end else if (dir_q != DIR_NONE) begin
                rev_d = rev_inc;
                if (rev_inc == REV_MAX) begin
                  lock_d = 1'b1;
                end
              end
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= '0;
      bk_q     <= '0;
      lock_q   <= 1'b0;
      sat_q    <= 1'b0;
      filt_q   <= '0;
      settle_q <= '0;
      rev_q    <= '0;
      dir_q    <= DIR_NONE;
      man_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values present before the edge, independent of statement order.
      state_q  <= state_d;
      code_q   <= code_d;
      bk_q     <= thermo(code_d);
      lock_q   <= lock_d;
      sat_q    <= sat_d;
      filt_q   <= filt_d;
      settle_q <= settle_d;
      rev_q    <= rev_d;
      dir_q    <= dir_d;
      man_q    <= man_d;
    end
  end

  assign bk   = bk_q;
  assign code = code_q;
  assign lock = lock_q;
  assign sat  = sat_q;

endmodule
